// File: rtl/x_pmcd_rel_seq.sv
// rtl/x_pmcd_rel_seq.sv - PMCD reset/release sequencer driven by DCM lock
// Option: PMCD_REL_SEQ_AUTO_REL_EN skips the REL_REQ wait and releases straight after the hold phase.
module x_pmcd_rel_seq #(
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int REL_WIDTH          = 2,
  parameter int CNT_WIDTH          = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       REL_REQ,
  input  logic       CLR_LOST,
  output logic       PMCD_RST,
  output logic       PMCD_REL,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [2:0] STATE
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_WAIT_REL  = 3'd3;
  localparam logic [2:0] S_REL       = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;

  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REL_LAST  = CNT_WIDTH'(REL_WIDTH - 1);

  logic                 lock_m;
  logic                 lock_s;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [2:0]           state_nxt;
  logic                 lost_evt;

  always_comb begin
    state_nxt = STATE;
    cnt_nxt   = cnt;
    lost_evt  = 1'b0;
    case (STATE)
      S_RESET: begin
        state_nxt = S_WAIT_LOCK;
        cnt_nxt   = '0;
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
`ifdef PMCD_REL_SEQ_AUTO_REL_EN
          state_nxt = S_REL;
`else
          state_nxt = S_WAIT_REL;
`endif
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (REL_REQ) begin
          state_nxt = S_REL;
          cnt_nxt   = '0;
        end
      end
      S_REL: begin
        // pulse width is owned by the counter; REL_REQ no longer matters here
        if (cnt == REL_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_RESET;
        cnt_nxt   = '0;
      end
    endcase

    // lock loss overrides every transition computed above
    if (!lock_s && (STATE == S_HOLD || STATE == S_WAIT_REL || STATE == S_REL || STATE == S_RUN)) begin
      lost_evt  = 1'b1;
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      STATE     <= S_RESET;
      cnt       <= '0;
      PMCD_RST  <= 1'b1;
      PMCD_REL  <= 1'b0;
      READY     <= 1'b0;
      LOCK_LOST <= 1'b0;
    end else begin
      lock_m    <= LOCKED;
      lock_s    <= lock_m;
      STATE     <= state_nxt;
      cnt       <= cnt_nxt;
      // outputs decode the next state so they flip on the same edge as STATE
      PMCD_RST  <= (state_nxt == S_RESET) || (state_nxt == S_WAIT_LOCK) || (state_nxt == S_HOLD);
      PMCD_REL  <= (state_nxt == S_REL);
      READY     <= (state_nxt == S_RUN);
      if (lost_evt) begin
        LOCK_LOST <= 1'b1;
      end else if (CLR_LOST) begin
        LOCK_LOST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x_pmcd_rel_seq.sv
// tb/tb_x_pmcd_rel_seq.sv - bench for x_pmcd_rel_seq
// Honours PMCD_REL_SEQ_AUTO_REL_EN when the bundle is built with it.
module tb_x_pmcd_rel_seq;

  localparam int LSC = 64;
  localparam int RHC = 16;
  localparam int RW  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOCKED = 1'b0;
  logic       REL_REQ = 1'b0;
  logic       CLR_LOST = 1'b0;
  logic       PMCD_RST;
  logic       PMCD_REL;
  logic       READY;
  logic       LOCK_LOST;
  logic [2:0] STATE;

  int tests = 0;
  int fails = 0;

  x_pmcd_rel_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .RST_HOLD_CYCLES(RHC),
    .REL_WIDTH(RW),
    .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .LOCKED(LOCKED),
    .REL_REQ(REL_REQ),
    .CLR_LOST(CLR_LOST),
    .PMCD_RST(PMCD_RST),
    .PMCD_REL(PMCD_REL),
    .READY(READY),
    .LOCK_LOST(LOCK_LOST),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase number plus age of the phase, lock seen two edges late.
  int   m_ph = 0;
  int   m_age = 0;
  logic m_lost = 1'b0;
  logic m_d1 = 1'b0;
  logic m_d2 = 1'b0;

  task automatic model_update();
    logic ls;
    if (RST) begin
      m_ph = 0; m_age = 0; m_lost = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    end else begin
      ls = m_d2;
      m_d2 = m_d1;
      m_d1 = LOCKED;
      if (m_ph >= 2 && !ls) begin
        m_ph = 1; m_age = 0; m_lost = 1'b1;
      end else begin
        if (CLR_LOST) m_lost = 1'b0;
        case (m_ph)
          0: begin m_ph = 1; m_age = 0; end
          1: begin
            m_age = ls ? m_age + 1 : 0;
            if (m_age == LSC) begin m_ph = 2; m_age = 0; end
          end
          2: begin
            m_age++;
            if (m_age == RHC) begin
`ifdef PMCD_REL_SEQ_AUTO_REL_EN
              m_ph = 4;
`else
              m_ph = 3;
`endif
              m_age = 0;
            end
          end
          3: if (REL_REQ) begin m_ph = 4; m_age = 0; end
          4: begin
            m_age++;
            if (m_age == RW) begin m_ph = 5; m_age = 0; end
          end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [2:0] st;
    st = 3'(m_ph);
    return {st, logic'(m_ph <= 2), logic'(m_ph == 4), logic'(m_ph == 5), m_lost};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {STATE, PMCD_RST, PMCD_REL, READY, LOCK_LOST};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got state=%0d rst=%b rel=%b ready=%b lost=%b, want state=%0d rst=%b rel=%b ready=%b lost=%b",
               name, act[6:4], act[3], act[2], act[1], act[0], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string name, input int st, input logic prst, input logic prel,
                            input logic rdy, input logic lost);
    chk(name, dut_vec(), {3'(st), prst, prel, rdy, lost});
  endtask

  // Reset, then LOCKED=1 from the release edge; ends on the edge that leaves S_HOLD.
  task automatic bring_up(input logic relreq);
    RST = 1'b1; LOCKED = 1'b0; REL_REQ = relreq; CLR_LOST = 1'b0;
    run(2);
    RST = 1'b0; LOCKED = 1'b1;
    run(LSC + 1);
    expect_out("bu_wait_lock", 1, 1, 0, 0, 0);
    run(1);
    expect_out("bu_hold_entry", 2, 1, 0, 0, 0);
    run(RHC - 1);
    expect_out("bu_hold_last", 2, 1, 0, 0, 0);
    run(1);
  endtask

  typedef struct {
    logic       rst;
    logic       locked;
    logic       relreq;
    logic       clr;
    int         n;
    int         st;
    logic       prst;
    logic       prel;
    logic       rdy;
    logic       lost;
  } vec_t;

  vec_t tbl[$];

  initial begin
`ifndef PMCD_REL_SEQ_AUTO_REL_EN
    // Reset, lock from cycle 5, full release, then lock loss and LOCK_LOST clear/set.
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3,  0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 65, 1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 15, 2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  3, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  4, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  4, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 5,  5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2,  5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1,  1, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 65, 1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1,  2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2,  2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1,  1, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int r = 0; r < tbl.size(); r++) begin
      RST = tbl[r].rst; LOCKED = tbl[r].locked; REL_REQ = tbl[r].relreq; CLR_LOST = tbl[r].clr;
      run(tbl[r].n);
      expect_out($sformatf("tbl_row%0d", r), tbl[r].st, tbl[r].prst, tbl[r].prel, tbl[r].rdy, tbl[r].lost);
    end

    // Single-cycle lock glitch after 40 stable synced cycles restarts the count.
    RST = 1'b1; LOCKED = 1'b0; REL_REQ = 1'b0; CLR_LOST = 1'b0;
    run(2);
    RST = 1'b0;
    run(1);
    LOCKED = 1'b1;
    run(42);
    LOCKED = 1'b0;
    run(1);
    LOCKED = 1'b1;
    run(65);
    expect_out("glitch_still_waiting", 1, 1, 0, 0, 0);
    run(1);
    expect_out("glitch_hold_entry", 2, 1, 0, 0, 0);

    // REL_REQ held low for 100 cycles in S_WAIT_REL, then the pulse.
    bring_up(1'b0);
    expect_out("wrel_entry", 3, 0, 0, 0, 0);
    run(100);
    expect_out("wrel_after100", 3, 0, 0, 0, 0);
    REL_REQ = 1'b1;
    run(1);
    expect_out("wrel_pulse1", 4, 0, 1, 0, 0);
    REL_REQ = 1'b0;
    run(1);
    expect_out("wrel_pulse2", 4, 0, 1, 0, 0);
    run(1);
    expect_out("wrel_run", 5, 0, 0, 1, 0);

    // RST during S_REL after one pulse cycle.
    bring_up(1'b0);
    REL_REQ = 1'b1;
    run(1);
    expect_out("rstrel_pulse", 4, 0, 1, 0, 0);
    RST = 1'b1;
    run(1);
    expect_out("rstrel_reset", 0, 1, 0, 0, 0);
`else
    // No REL_REQ: release follows the 16th hold cycle directly.
    bring_up(1'b0);
    expect_out("auto_rel1", 4, 0, 1, 0, 0);
    run(1);
    expect_out("auto_rel2", 4, 0, 1, 0, 0);
    run(1);
    expect_out("auto_run", 5, 0, 0, 1, 0);
    RST = 1'b1;
    run(1);
    expect_out("auto_reset", 0, 1, 0, 0, 0);
`endif

    // Randomized bursts of lock level against the model.
    RST = 1'b1;
    run(2);
    RST = 1'b0;
    for (int b = 0; b < 60; b++) begin
      int len;
      len = $urandom_range(1, 150);
      LOCKED = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) begin
        REL_REQ  = ($urandom_range(0, 7) == 0);
        CLR_LOST = ($urandom_range(0, 15) == 0);
        RST      = ($urandom_range(0, 499) == 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
